// File: rtl/hazard_ctrl.sv
// hazard_ctrl: SELEN pipeline stall/flush controller with data-wait timeout and wrong-path fetch kill.
// Revision 1.0
`default_nettype none

module hazard_ctrl #(
  parameter int DMEM_TIMEOUT = 15,
  parameter int TO_W         = 4,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_ack,
  input  logic             dmem_reqM,
  input  logic             dmem_ack,
  input  logic             brch_takenM,
  input  logic             ld_E,
  input  logic [4:0]       rdE,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  output logic             enbF,
  output logic             enbD,
  output logic             enbE,
  output logic             enbM,
  output logic             flashD,
  output logic             flashE,
  output logic             flashM,
  output logic             flashW,
  output logic             pc_redir,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DWAIT = 1'b1
  } state_t;

  localparam logic [TO_W-1:0] TIMEOUT = TO_W'(DMEM_TIMEOUT);

  state_t          state, state_nxt;
  logic [TO_W-1:0] wait_cnt, wait_cnt_nxt;
  logic            kill, kill_nxt;
  logic            dpend, dstall, timeout, load_use, fetch_miss;

  assign dpend      = dmem_reqM & ~dmem_ack;
  assign dstall     = dpend & (wait_cnt < TIMEOUT);
  assign timeout    = dpend & (wait_cnt == TIMEOUT);
  assign load_use   = ld_E & (rdE != 5'd0) & ((rdE == rs1D) | (rdE == rs2D));
  // A returning instruction while kill is set belongs to the abandoned path.
  assign fetch_miss = ~imem_ack | kill;

  always_comb begin
    enbF     = 1'b0;
    enbD     = 1'b0;
    enbE     = 1'b0;
    enbM     = 1'b0;
    flashD   = 1'b0;
    flashE   = 1'b0;
    flashM   = 1'b0;
    flashW   = 1'b0;
    pc_redir = 1'b0;
    if (rst) begin
      flashD = 1'b1;
      flashE = 1'b1;
      flashM = 1'b1;
      flashW = 1'b1;
    end else if (dstall) begin
      enbF   = 1'b1;
      enbD   = 1'b1;
      enbE   = 1'b1;
      enbM   = 1'b1;
      flashW = 1'b1;
    end else if (brch_takenM) begin
      flashD   = 1'b1;
      flashE   = 1'b1;
      flashM   = 1'b1;
      pc_redir = 1'b1;
    end else if (load_use) begin
      enbF   = 1'b1;
      enbD   = 1'b1;
      flashE = 1'b1;
    end else if (fetch_miss) begin
      enbF   = 1'b1;
      flashD = 1'b1;
    end
  end

  always_comb begin
    state_nxt    = RUN;
    wait_cnt_nxt = '0;
    case (state)
      RUN: begin
        if (dstall) begin
          state_nxt    = DWAIT;
          wait_cnt_nxt = TO_W'(1);
        end
      end
      DWAIT: begin
        // Ack, dropped request or timeout all return to RUN with a cleared count.
        if (dstall) begin
          state_nxt    = DWAIT;
          wait_cnt_nxt = wait_cnt + TO_W'(1);
        end
      end
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    kill_nxt = kill;
    if (pc_redir && !imem_ack) begin
      kill_nxt = 1'b1;
    end else if (imem_ack) begin
      kill_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      kill      <= 1'b0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      kill     <= kill_nxt;
      if (timeout) begin
        mem_err <= 1'b1;
      end
      if (enbF && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire
